// File: rtl/wimax_qam_mapper_if.sv
// Symbol mapper bus: serial coded-bit input side plus registered I/Q output side.
// master drives the coded bits and mode; slave is the mapper itself.
interface wimax_qam_mapper_if #(
  parameter int O = 16
);
  logic                i;
  logic                i_valid;
  logic                i_last;
  logic [1:0]          mode;
  logic signed [O-1:0] I;
  logic signed [O-1:0] Q;
  logic                qi_valid;
  logic                qi_last;
  logic                qi_pad;

  modport master (
    output i, i_valid, i_last, mode,
    input  I, Q, qi_valid, qi_last, qi_pad
  );

  modport slave (
    input  i, i_valid, i_last, mode,
    output I, Q, qi_valid, qi_last, qi_pad
  );
endinterface

// File: rtl/wimax_qam_mapper.sv
// WIMAX symbol mapper: packs serial coded bits into BPSK/QPSK/16QAM/64QAM Gray-mapped I/Q.
// Optional WIMAX_MAPPER_NORM_EN adds a per-mode Q0.15 normalisation stage (latency 2).
module wimax_qam_mapper #(
  parameter int O    = 16,
  parameter int UNIT = 4096
) (
  input logic               clk,
  input logic               reset,
  wimax_qam_mapper_if.slave bus
);
  localparam int W  = O + 4;
  localparam int WX = O + 21;
  localparam logic signed [WX-1:0] SAT_MAX = (WX'(1) << (O - 1)) - WX'(1);
  localparam logic signed [WX-1:0] SAT_MIN = -SAT_MAX;
  localparam logic signed [W-1:0]  UNIT_W  = W'(UNIT);

  typedef enum logic {EMPTY, FILL} state_t;

  function automatic logic [2:0] bits_per_sym(input logic [1:0] m);
    case (m)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      2'd2:    return 3'd4;
      default: return 3'd6;
    endcase
  endfunction

  // Gray code (MSB first) of width w -> signed constellation level
  function automatic logic signed [3:0] gray_level(input logic [2:0] b, input logic [1:0] w);
    logic signed [3:0] lv;
    lv = 4'sd0;
    case (w)
      2'd1: lv = b[0] ? -4'sd1 : 4'sd1;
      2'd2: begin
        case (b[1:0])
          2'b00:   lv = -4'sd3;
          2'b01:   lv = -4'sd1;
          2'b11:   lv = 4'sd1;
          default: lv = 4'sd3;
        endcase
      end
      default: begin
        case (b)
          3'b000:  lv = -4'sd7;
          3'b001:  lv = -4'sd5;
          3'b011:  lv = -4'sd3;
          3'b010:  lv = -4'sd1;
          3'b110:  lv = 4'sd1;
          3'b111:  lv = 4'sd3;
          3'b101:  lv = 4'sd5;
          default: lv = 4'sd7;
        endcase
      end
    endcase
    return lv;
  endfunction

  function automatic logic signed [O-1:0] saturate(input logic signed [WX-1:0] x);
    if (x > SAT_MAX) return SAT_MAX[O-1:0];
    if (x < SAT_MIN) return SAT_MIN[O-1:0];
    return x[O-1:0];
  endfunction

  state_t      state_reg, state_next;
  logic [2:0]  count_reg, count_next;
  logic [4:0]  bits_reg, bits_next;
  logic [1:0]  mode_reg, mode_next;
  logic [1:0]  sym_mode;
  logic [5:0]  acc_bits, sym_bits;
  logic [2:0]  acc_count, nb;
  logic        done, padded;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= EMPTY;
      count_reg <= 3'd0;
      bits_reg  <= 5'd0;
      mode_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      bits_reg  <= bits_next;
      mode_reg  <= mode_next;
    end
  end

  // The mode is sampled only on the first bit of a symbol; later changes wait.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    bits_next  = bits_reg;
    mode_next  = mode_reg;
    sym_mode   = mode_reg;
    acc_bits   = {bits_reg, bus.i};
    acc_count  = count_reg + 3'd1;
    done       = 1'b0;
    padded     = 1'b0;
    sym_bits   = 6'd0;
    if (state_reg == EMPTY) begin
      sym_mode  = bus.mode;
      acc_bits  = {5'd0, bus.i};
      acc_count = 3'd1;
    end
    nb = bits_per_sym(sym_mode);
    if (bus.i_valid) begin
      mode_next = sym_mode;
      if (acc_count == nb || bus.i_last) begin
        done       = 1'b1;
        padded     = (acc_count != nb);
        sym_bits   = acc_bits << (nb - acc_count);
        state_next = EMPTY;
        count_next = 3'd0;
        bits_next  = 5'd0;
      end else begin
        state_next = FILL;
        count_next = acc_count;
        bits_next  = acc_bits[4:0];
      end
    end
  end

  logic signed [3:0]   lvl_i, lvl_q;
  logic signed [W-1:0] amp_i, amp_q;

  always_comb begin
    lvl_i = 4'sd0;
    lvl_q = 4'sd0;
    case (sym_mode)
      2'd0: lvl_i = gray_level({2'b00, sym_bits[0]}, 2'd1);
      2'd1: begin
        lvl_i = gray_level({2'b00, sym_bits[1]}, 2'd1);
        lvl_q = gray_level({2'b00, sym_bits[0]}, 2'd1);
      end
      2'd2: begin
        lvl_i = gray_level({1'b0, sym_bits[3:2]}, 2'd2);
        lvl_q = gray_level({1'b0, sym_bits[1:0]}, 2'd2);
      end
      default: begin
        lvl_i = gray_level(sym_bits[5:3], 2'd3);
        lvl_q = gray_level(sym_bits[2:0], 2'd3);
      end
    endcase
  end

  assign amp_i = W'(lvl_i) * UNIT_W;
  assign amp_q = W'(lvl_q) * UNIT_W;

  logic signed [O-1:0] i_out_reg, q_out_reg;
  logic                valid_reg, last_reg, pad_reg;

`ifdef WIMAX_MAPPER_NORM_EN
  logic [15:0]          k_sel;
  logic signed [W-1:0]  s1_i_reg, s1_q_reg;
  logic [15:0]          s1_k_reg;
  logic                 s1_valid_reg, s1_last_reg, s1_pad_reg;
  logic signed [WX-1:0] norm_i, norm_q;

  always_comb begin
    case (sym_mode)
      2'd0:    k_sel = 16'd32767;
      2'd1:    k_sel = 16'd23170;
      2'd2:    k_sel = 16'd10362;
      default: k_sel = 16'd5056;
    endcase
  end

  // Arithmetic right shift floors the Q0.15 product
  assign norm_i = (WX'(s1_i_reg) * WX'($signed({1'b0, s1_k_reg}))) >>> 15;
  assign norm_q = (WX'(s1_q_reg) * WX'($signed({1'b0, s1_k_reg}))) >>> 15;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_i_reg     <= '0;
      s1_q_reg     <= '0;
      s1_k_reg     <= 16'd0;
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_pad_reg   <= 1'b0;
      i_out_reg    <= '0;
      q_out_reg    <= '0;
      valid_reg    <= 1'b0;
      last_reg     <= 1'b0;
      pad_reg      <= 1'b0;
    end else begin
      s1_valid_reg <= done;
      s1_last_reg  <= done & bus.i_last;
      s1_pad_reg   <= padded;
      if (done) begin
        s1_i_reg <= amp_i;
        s1_q_reg <= amp_q;
        s1_k_reg <= k_sel;
      end
      valid_reg <= s1_valid_reg;
      last_reg  <= s1_last_reg;
      pad_reg   <= s1_pad_reg;
      if (s1_valid_reg) begin
        i_out_reg <= saturate(norm_i);
        q_out_reg <= saturate(norm_q);
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_out_reg <= '0;
      q_out_reg <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      pad_reg   <= 1'b0;
    end else begin
      valid_reg <= done;
      last_reg  <= done & bus.i_last;
      pad_reg   <= padded;
      if (done) begin
        i_out_reg <= saturate(WX'(amp_i));
        q_out_reg <= saturate(WX'(amp_q));
      end
    end
  end
`endif

  assign bus.I        = i_out_reg;
  assign bus.Q        = q_out_reg;
  assign bus.qi_valid = valid_reg;
  assign bus.qi_last  = last_reg;
  assign bus.qi_pad   = pad_reg;
endmodule

// File: tb/tb_wimax_qam_mapper.sv
// Self-checking bench for wimax_qam_mapper: directed spec vectors plus randomized bursts
// checked against a queue-based symbol model.
module tb_wimax_qam_mapper;
  localparam int O    = 16;
  localparam int UNIT = 4096;
`ifdef WIMAX_MAPPER_NORM_EN
  localparam int LAT  = 2;
  localparam bit NORM = 1'b1;
`else
  localparam int LAT  = 1;
  localparam bit NORM = 1'b0;
`endif

  typedef struct {
    logic signed [15:0] i;
    logic signed [15:0] q;
    logic               last;
    logic               pad;
    int                 cyc;
  } sym_t;

  logic clk = 1'b0;
  logic reset;

  wimax_qam_mapper_if #(.O(O)) bus();
  wimax_qam_mapper #(.O(O), .UNIT(UNIT)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  int   stamp = 0;
  int   pmode = 0;
  sym_t obs[$];
  sym_t exp_q[$];
  sym_t mon_s;
  bit   pend[$];
  int   nbt[4] = '{1, 2, 4, 6};
  int   kk[4]  = '{32767, 23170, 10362, 5056};
  int   g1[2]  = '{1, -1};
  int   g2[4]  = '{-3, -1, 3, 1};
  int   g3[8]  = '{-7, -5, -1, -3, 7, 5, 1, 3};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset && bus.qi_valid) begin
      mon_s.i    = bus.I;
      mon_s.q    = bus.Q;
      mon_s.last = bus.qi_last;
      mon_s.pad  = bus.qi_pad;
      mon_s.cyc  = cyc;
      obs.push_back(mon_s);
    end
  end

  function automatic logic signed [15:0] scale(input int lvl, input int m);
    longint v;
    v = longint'(lvl) * UNIT;
    if (NORM) v = (v * kk[m]) >>> 15;
    if (v > 32767) v = 32767;
    if (v < -32767) v = -32767;
    return 16'(v);
  endfunction

  function automatic void model_complete(input int st, input bit last);
    int   nb;
    int   val;
    sym_t e;
    nb    = nbt[pmode];
    e.pad = (pend.size() < nb);
    while (pend.size() < nb) pend.push_back(1'b0);
    val = 0;
    foreach (pend[k]) val = val * 2 + int'(pend[k]);
    pend.delete();
    case (pmode)
      0: begin e.i = scale(g1[val], 0); e.q = 16'sd0; end
      1: begin e.i = scale(g1[val >> 1], 1); e.q = scale(g1[val & 1], 1); end
      2: begin e.i = scale(g2[val >> 2], 2); e.q = scale(g2[val & 3], 2); end
      default: begin e.i = scale(g3[val >> 3], 3); e.q = scale(g3[val & 7], 3); end
    endcase
    e.last = last;
    e.cyc  = st + LAT;
    exp_q.push_back(e);
  endfunction

  task automatic send_bit(input bit b, input int m, input bit last);
    @(negedge clk);
    bus.i       = b;
    bus.i_valid = 1'b1;
    bus.i_last  = last;
    bus.mode    = 2'(m);
    stamp       = cyc;
    if (pend.size() == 0) pmode = m;
    pend.push_back(b);
    if (pend.size() == nbt[pmode] || last) model_complete(stamp, last);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_last  = 1'($urandom_range(0, 1));
      bus.i       = 1'($urandom_range(0, 1));
      bus.mode    = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (bus.I !== 16'sd0) begin errors++; $display("FAIL reset_I: got %0d, expected 0", bus.I); end
    vectors++; if (bus.Q !== 16'sd0) begin errors++; $display("FAIL reset_Q: got %0d, expected 0", bus.Q); end
    vectors++; if (bus.qi_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", bus.qi_valid); end
    vectors++; if (bus.qi_last !== 1'b0 || bus.qi_pad !== 1'b0) begin
      errors++; $display("FAIL reset_last_pad: got %b%b, expected 00", bus.qi_last, bus.qi_pad);
    end
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_bpsk();
    int t0;
    obs.delete(); exp_q.delete();
    send_bit(1'b0, 0, 1'b0);
    t0 = stamp;
    send_bit(1'b1, 0, 1'b0);
    idle(LAT + 2);
    vectors++;
    if (obs.size() != 2) begin errors++; $display("FAIL bpsk_count: got %0d, expected 2", obs.size()); end
    else begin
      vectors++; if (obs[0].i !== scale(1, 0) || obs[0].q !== 16'sd0) begin
        errors++; $display("FAIL bpsk_sym0: got I=%0d Q=%0d, expected I=%0d Q=0", obs[0].i, obs[0].q, scale(1, 0));
      end
      vectors++; if (obs[1].i !== scale(-1, 0) || obs[1].q !== 16'sd0) begin
        errors++; $display("FAIL bpsk_sym1: got I=%0d Q=%0d, expected I=%0d Q=0", obs[1].i, obs[1].q, scale(-1, 0));
      end
      vectors++; if (obs[0].cyc != t0 + LAT || obs[1].cyc != t0 + LAT + 1) begin
        errors++; $display("FAIL bpsk_latency: got cycles %0d,%0d, expected %0d,%0d", obs[0].cyc, obs[1].cyc, t0 + LAT, t0 + LAT + 1);
      end
    end
  endtask

  task automatic test_qpsk_64qam();
    obs.delete(); exp_q.delete();
    send_bit(1'b1, 1, 1'b0);
    send_bit(1'b0, 1, 1'b0);
    idle(LAT + 2);
    vectors++;
    if (obs.size() != 1) begin errors++; $display("FAIL qpsk_count: got %0d, expected 1", obs.size()); end
    else if (obs[0].i !== scale(-1, 1) || obs[0].q !== scale(1, 1) || obs[0].pad !== 1'b0) begin
      errors++; $display("FAIL qpsk_sym: got I=%0d Q=%0d pad=%b, expected I=%0d Q=%0d pad=0", obs[0].i, obs[0].q, obs[0].pad, scale(-1, 1), scale(1, 1));
    end
    obs.delete();
    send_bit(1'b1, 3, 1'b0); send_bit(1'b0, 3, 1'b0); send_bit(1'b0, 3, 1'b0);
    send_bit(1'b0, 3, 1'b0); send_bit(1'b1, 3, 1'b0); send_bit(1'b0, 3, 1'b0);
    idle(LAT + 2);
    vectors++;
    if (obs.size() != 1) begin errors++; $display("FAIL qam64_count: got %0d, expected 1", obs.size()); end
    else if (obs[0].i !== scale(7, 3) || obs[0].q !== scale(-1, 3)) begin
      errors++; $display("FAIL qam64_sym: got I=%0d Q=%0d, expected I=%0d Q=%0d", obs[0].i, obs[0].q, scale(7, 3), scale(-1, 3));
    end
  endtask

  task automatic test_flush();
    obs.delete(); exp_q.delete();
    send_bit(1'b1, 2, 1'b0);
    send_bit(1'b1, 2, 1'b0);
    send_bit(1'b0, 2, 1'b1);
    idle(LAT + 2);
    vectors++;
    if (obs.size() != 1) begin errors++; $display("FAIL flush_count: got %0d, expected 1", obs.size()); end
    else if (obs[0].i !== scale(1, 2) || obs[0].q !== scale(-3, 2) || obs[0].last !== 1'b1 || obs[0].pad !== 1'b1) begin
      errors++; $display("FAIL flush_sym: got I=%0d Q=%0d last=%b pad=%b, expected I=%0d Q=%0d last=1 pad=1",
                         obs[0].i, obs[0].q, obs[0].last, obs[0].pad, scale(1, 2), scale(-3, 2));
    end
  endtask

  task automatic test_mode_switch();
    obs.delete(); exp_q.delete();
    send_bit(1'b1, 2, 1'b0);
    send_bit(1'b0, 2, 1'b0);
    send_bit(1'b1, 0, 1'b0);
    send_bit(1'b1, 0, 1'b0);
    send_bit(1'b0, 0, 1'b0);
    idle(LAT + 2);
    vectors++;
    if (obs.size() != 2) begin errors++; $display("FAIL switch_count: got %0d, expected 2", obs.size()); end
    else begin
      vectors++; if (obs[0].i !== scale(3, 2) || obs[0].q !== scale(1, 2)) begin
        errors++; $display("FAIL switch_qam16: got I=%0d Q=%0d, expected I=%0d Q=%0d", obs[0].i, obs[0].q, scale(3, 2), scale(1, 2));
      end
      vectors++; if (obs[1].i !== scale(1, 0) || obs[1].q !== 16'sd0) begin
        errors++; $display("FAIL switch_bpsk: got I=%0d Q=%0d, expected I=%0d Q=0", obs[1].i, obs[1].q, scale(1, 0));
      end
    end
  endtask

  task automatic test_reset_mid();
    obs.delete(); exp_q.delete();
    send_bit(1'b1, 2, 1'b0);
    send_bit(1'b1, 2, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    bus.i_valid = 1'b0;
    pend.delete();
    pmode = 0;
    repeat (2) @(negedge clk);
    vectors++; if (bus.I !== 16'sd0 || bus.Q !== 16'sd0 || bus.qi_valid !== 1'b0 || obs.size() != 0) begin
      errors++; $display("FAIL midreset_out: got I=%0d Q=%0d valid=%b syms=%0d, expected 0 0 0 0", bus.I, bus.Q, bus.qi_valid, obs.size());
    end
    reset = 1'b1;
    idle(1);
    repeat (4) send_bit(1'b0, 2, 1'b0);
    idle(LAT + 2);
    vectors++;
    if (obs.size() != 1) begin errors++; $display("FAIL midreset_count: got %0d, expected 1", obs.size()); end
    else if (obs[0].i !== scale(-3, 2) || obs[0].q !== scale(-3, 2) || obs[0].pad !== 1'b0) begin
      errors++; $display("FAIL midreset_sym: got I=%0d Q=%0d pad=%b, expected I=%0d Q=%0d pad=0", obs[0].i, obs[0].q, obs[0].pad, scale(-3, 2), scale(-3, 2));
    end
  endtask

`ifdef WIMAX_MAPPER_NORM_EN
  task automatic test_norm();
    int t0;
    obs.delete(); exp_q.delete();
    send_bit(1'b0, 1, 1'b0);
    send_bit(1'b0, 1, 1'b0);
    t0 = stamp;
    idle(4);
    vectors++;
    if (obs.size() != 1) begin errors++; $display("FAIL norm_qpsk_count: got %0d, expected 1", obs.size()); end
    else if (obs[0].i !== 16'sd2896 || obs[0].q !== 16'sd2896 || obs[0].cyc != t0 + 2) begin
      errors++; $display("FAIL norm_qpsk: got I=%0d Q=%0d cyc=%0d, expected 2896 2896 %0d", obs[0].i, obs[0].q, obs[0].cyc, t0 + 2);
    end
    obs.delete();
    repeat (4) send_bit(1'b1, 2, 1'b0);
    idle(4);
    vectors++;
    if (obs.size() != 1) begin errors++; $display("FAIL norm_qam16_count: got %0d, expected 1", obs.size()); end
    else if (obs[0].i !== 16'sd1295 || obs[0].q !== 16'sd1295) begin
      errors++; $display("FAIL norm_qam16: got I=%0d Q=%0d, expected 1295 1295", obs[0].i, obs[0].q);
    end
  endtask
`endif

  task automatic test_random();
    int n;
    obs.delete(); exp_q.delete();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) < 7)
        send_bit(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), ($urandom_range(0, 11) == 0));
      else
        idle(1);
    end
    send_bit(1'($urandom_range(0, 1)), 0, 1'b1);
    idle(LAT + 2);
    vectors++;
    if (obs.size() != exp_q.size()) begin
      errors++; $display("FAIL random_count: got %0d, expected %0d", obs.size(), exp_q.size());
    end
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      vectors++;
      if (obs[k].i !== exp_q[k].i || obs[k].q !== exp_q[k].q || obs[k].last !== exp_q[k].last ||
          obs[k].pad !== exp_q[k].pad || obs[k].cyc != exp_q[k].cyc) begin
        errors++;
        $display("FAIL random_sym%0d: got I=%0d Q=%0d last=%b pad=%b cyc=%0d, expected I=%0d Q=%0d last=%b pad=%b cyc=%0d",
                 k, obs[k].i, obs[k].q, obs[k].last, obs[k].pad, obs[k].cyc,
                 exp_q[k].i, exp_q[k].q, exp_q[k].last, exp_q[k].pad, exp_q[k].cyc);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    obs.delete(); exp_q.delete();
    for (int k = 0; k < 32; k++) send_bit(1'($urandom_range(0, 1)), 0, 1'b0);
    for (int k = 0; k < 23; k++) send_bit(1'($urandom_range(0, 1)), 3, (k == 22));
    for (int k = 0; k < 8; k++) send_bit(1'($urandom_range(0, 1)), 1, 1'b0);
    idle(LAT + 2);
    vectors++;
    if (obs.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count: got %0d, expected %0d", obs.size(), exp_q.size());
    end
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      vectors++;
      if (obs[k].i !== exp_q[k].i || obs[k].q !== exp_q[k].q || obs[k].last !== exp_q[k].last ||
          obs[k].pad !== exp_q[k].pad || obs[k].cyc != exp_q[k].cyc) begin
        errors++;
        $display("FAIL b2b_sym%0d: got I=%0d Q=%0d last=%b pad=%b cyc=%0d, expected I=%0d Q=%0d last=%b pad=%b cyc=%0d",
                 k, obs[k].i, obs[k].q, obs[k].last, obs[k].pad, obs[k].cyc,
                 exp_q[k].i, exp_q[k].q, exp_q[k].last, exp_q[k].pad, exp_q[k].cyc);
      end
    end
  endtask

  initial begin
    reset       = 1'b0;
    bus.i       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    bus.mode    = 2'd0;
    test_reset();
    test_bpsk();
    test_qpsk_64qam();
    test_flush();
    test_mode_switch();
    test_reset_mid();
`ifdef WIMAX_MAPPER_NORM_EN
    test_norm();
`endif
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
